data_mem_unit: RTL

- Downstream memory stage of the single-cycle RISC-V datapath.
- Consumes ALUResult (address), WriteData, MemWrite/MemRead and funct3.
- Returns ReadData to the datapath's result mux.
- Models a multi-cycle backing RAM behind a small FSM. It asserts Stall so the controller freezes PC and register writeback until the access completes. Sub-word loads and stores, sign/zero extension and misalignment detection are handled here.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/load_store_align.sv | 53 +++++
 rtl/data_mem_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared state encoding, Funct3 codes and legality helper for the
//             data memory stage.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True for an unaligned halfword/word access or an unknown width code.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_align
//  Purpose  : Byte-lane steering for stores and lane extraction/extension
//             for loads.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_byte_en    = 4'b0000;
        o_store_word = 32'h0;
        o_load_data  = 32'h0;
        w_byte       = i_load_word[{i_addr_lo, 3'b000} +: 8];
        w_half       = i_load_word[{i_addr_lo[1], 4'b0000} +: 16];
        // Store data is replicated to every lane; the enable mask picks the target.
        case (i_funct3)
            F3_B: begin
                o_byte_en    = 4'b0001 << i_addr_lo;
                o_store_word = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_store_word = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_half[15]}}, w_half};
            end
            F3_W: begin
                o_byte_en    = 4'b1111;
                o_store_word = i_store_data;
                o_load_data  = i_load_word;
            end
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_unit
//  Purpose  : Multi-cycle data memory stage with sub-word access, stall
//             generation and misalignment detection.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_lo;
    logic [2:0]      r_f3;
    logic [31:0]     r_wdata;
    logic            r_is_store;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_bad;
    logic            w_accept;
    logic            w_commit;
    logic [31:0]     w_rword;
    logic [3:0]      w_be;
    logic [31:0]     w_store_word;
    logic [31:0]     w_load_data;
    logic            w_unused;

    // Address bits above the array span are intentionally dropped (wrap-around).
    assign w_unused   = ^Addr[31:AW+2];

    assign w_req      = MemRead | MemWrite;
    assign w_bad      = is_misaligned(Funct3, Addr[1:0]) | (MemWrite & Funct3[2]);
    assign Misaligned = w_req & w_bad;
    assign w_accept   = (r_state == IDLE) & w_req & ~w_bad;
    assign Stall      = w_accept | (r_state == WAIT);
    assign w_commit   = (r_state == WAIT) && (r_cnt == '0);
    assign w_rword    = r_mem[r_idx];
    assign ReadData   = r_rdata;

    load_store_align u_align (
        .i_funct3     (r_f3),
        .i_addr_lo    (r_lo),
        .i_store_data (r_wdata),
        .i_load_word  (w_rword),
        .o_byte_en    (w_be),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_lo       <= '0;
            r_f3       <= '0;
            r_wdata    <= '0;
            r_is_store <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx      <= Addr[AW+1:2];
                        r_lo       <= Addr[1:0];
                        r_f3       <= Funct3;
                        r_wdata    <= WriteData;
                        r_is_store <= MemWrite;
                        r_cnt      <= CW'(LATENCY - 1);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_is_store)
                            r_rdata <= w_load_data;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // DONE ignores inputs so the held instruction is not reissued.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array has no reset; a reset during WAIT leaves IDLE, so w_commit never fires.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[r_idx][8*i +: 8] <= w_store_word[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
